// File: rtl/inertial_sequencer.sv
// rtl/inertial_sequencer.sv - IMU bring-up and pitch-rate/accel-Z read sequencer over SPI
module inertial_sequencer #(
    parameter int TMR_W = 16
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        INT,
    input  logic        spi_done,
    input  logic [7:0]  spi_rd_data,
    output logic        wrt,
    output logic [15:0] cmd,
    output logic        vld,
    output logic [15:0] ptch_rt,
    output logic [15:0] AZ
);

    typedef enum logic [3:0] {
        SETTLE, CFG0, CFG1, CFG2, CFG3, IDLE,
        RD_PL, RD_PH, RD_AL, RD_AH, DONE
    } state_t;

    state_t           state;
    state_t           state_nxt;
    logic [TMR_W-1:0] tmr;
    logic             int_ff1;
    logic             int_ff2;
    logic             first;
    logic             xact;
    logic             adv;

    // spi_done only counts once the start pulse has already gone out
    always_comb begin
        xact = state inside {CFG0, CFG1, CFG2, CFG3, RD_PL, RD_PH, RD_AL, RD_AH};
        adv  = xact && spi_done && !first;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            SETTLE: if (tmr == {TMR_W{1'b1}}) state_nxt = CFG0;
            CFG0:   if (adv) state_nxt = CFG1;
            CFG1:   if (adv) state_nxt = CFG2;
            CFG2:   if (adv) state_nxt = CFG3;
            CFG3:   if (adv) state_nxt = IDLE;
            IDLE:   if (int_ff2) state_nxt = RD_PL;
            RD_PL:  if (adv) state_nxt = RD_PH;
            RD_PH:  if (adv) state_nxt = RD_AL;
            RD_AL:  if (adv) state_nxt = RD_AH;
            RD_AH:  if (adv) state_nxt = DONE;
            DONE:   state_nxt = IDLE;
            default: state_nxt = SETTLE;
        endcase
    end

    always_comb begin
        cmd = 16'h0000;
        case (state)
            CFG0:    cmd = 16'h0D02;
            CFG1:    cmd = 16'h1053;
            CFG2:    cmd = 16'h1150;
            CFG3:    cmd = 16'h1460;
            RD_PL:   cmd = 16'hA400;
            RD_PH:   cmd = 16'hA500;
            RD_AL:   cmd = 16'hAC00;
            RD_AH:   cmd = 16'hAD00;
            default: cmd = 16'h0000;
        endcase
        wrt = first && xact;
        vld = (state == DONE);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state   <= SETTLE;
            tmr     <= '0;
            int_ff1 <= 1'b0;
            int_ff2 <= 1'b0;
            first   <= 1'b0;
            ptch_rt <= 16'h0000;
            AZ      <= 16'h0000;
        end else begin
            state   <= state_nxt;
            int_ff1 <= INT;
            int_ff2 <= int_ff1;
            // first marks the opening cycle of every newly entered state
            first   <= (state_nxt != state);
            if (state == SETTLE && tmr != {TMR_W{1'b1}})
                tmr <= tmr + {{(TMR_W-1){1'b0}}, 1'b1};
            if (adv) begin
                case (state)
                    RD_PL:   ptch_rt[7:0]  <= spi_rd_data;
                    RD_PH:   ptch_rt[15:8] <= spi_rd_data;
                    RD_AL:   AZ[7:0]       <= spi_rd_data;
                    RD_AH:   AZ[15:8]      <= spi_rd_data;
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_inertial_sequencer.sv
// tb/tb_inertial_sequencer.sv - self-checking bench for inertial_sequencer
module tb_inertial_sequencer;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        INT = 1'b0;
    logic        spi_done = 1'b0;
    logic [7:0]  spi_rd_data = 8'h00;
    logic        wrt;
    logic [15:0] cmd;
    logic        vld;
    logic [15:0] ptch_rt;
    logic [15:0] AZ;

    int n_pass = 0;
    int n_total = 0;
    int wrt_cnt = 0;
    int vld_cnt = 0;
    logic [15:0] exp_p = 16'h0000;
    logic [15:0] exp_a = 16'h0000;

    inertial_sequencer #(.TMR_W(4)) dut (
        .clk(clk), .rst_n(rst_n), .INT(INT), .spi_done(spi_done),
        .spi_rd_data(spi_rd_data), .wrt(wrt), .cmd(cmd), .vld(vld),
        .ptch_rt(ptch_rt), .AZ(AZ)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (wrt === 1'b1) wrt_cnt++;
        if (vld === 1'b1) vld_cnt++;
    end

    task automatic serve(input logic [15:0] ecmd, input logic [7:0] rsp, input int dly,
                         input bit spur, input string nm);
        int n = 0;
        spi_done = 1'b0;
        while (wrt !== 1'b1 && n < 64) begin
            @(negedge clk);
            n++;
        end
        n_total++;
        if (wrt !== 1'b1) $display("FAIL %s wrt_timeout: got %b want 1", nm, wrt);
        else n_pass++;
        n_total++;
        if (cmd !== ecmd) $display("FAIL %s cmd: got %h want %h", nm, cmd, ecmd);
        else n_pass++;
        if (spur) begin
            spi_done = 1'b1;
            spi_rd_data = ~rsp;
        end
        for (int i = 0; i < dly; i++) begin
            @(negedge clk);
            spi_done = 1'b0;
            n_total++;
            if (wrt !== 1'b0 || cmd !== ecmd)
                $display("FAIL %s hold: wrt=%b cmd=%h want wrt=0 cmd=%h", nm, wrt, cmd, ecmd);
            else n_pass++;
            if (i == dly - 1) begin
                spi_done = 1'b1;
                spi_rd_data = rsp;
            end
        end
        @(negedge clk);
        spi_done = 1'b0;
    endtask

    task automatic burst(input logic [3:0][7:0] b, input int dmax, input bit keep_int,
                         input bit spur, input string nm);
        int vc = vld_cnt;
        serve(16'hA400, b[0], $urandom_range(1, dmax), spur, nm);
        if (!keep_int) INT = 1'b0;
        serve(16'hA500, b[1], $urandom_range(1, dmax), 1'b0, nm);
        serve(16'hAC00, b[2], $urandom_range(1, dmax), 1'b0, nm);
        serve(16'hAD00, b[3], $urandom_range(1, dmax), 1'b0, nm);
        exp_p = {b[1], b[0]};
        exp_a = {b[3], b[2]};
        n_total++;
        if (vld !== 1'b1) $display("FAIL %s vld: got %b want 1", nm, vld);
        else n_pass++;
        n_total++;
        if (ptch_rt !== exp_p) $display("FAIL %s ptch_rt: got %h want %h", nm, ptch_rt, exp_p);
        else n_pass++;
        n_total++;
        if (AZ !== exp_a) $display("FAIL %s AZ: got %h want %h", nm, AZ, exp_a);
        else n_pass++;
        @(negedge clk);
        n_total++;
        if (vld !== 1'b0 || vld_cnt != vc + 1)
            $display("FAIL %s vld_pulse: vld=%b count=%0d want 0/%0d", nm, vld, vld_cnt - vc, 1);
        else n_pass++;
    endtask

    task automatic run_init(input string nm);
        int cyc = 0;
        int wc;
        while (wrt !== 1'b1 && cyc < 64) begin
            @(negedge clk);
            spi_done = 1'b0;
            cyc++;
        end
        n_total++;
        if (cyc != 16) $display("FAIL %s settle_cycles: got %0d want 16", nm, cyc);
        else n_pass++;
        serve(16'h0D02, 8'h00, 3, 1'b0, nm);
        serve(16'h1053, 8'h00, 3, 1'b0, nm);
        serve(16'h1150, 8'h00, 3, 1'b0, nm);
        serve(16'h1460, 8'h00, 3, 1'b0, nm);
        wc = wrt_cnt;
        repeat (20) @(negedge clk);
        n_total++;
        if (wrt_cnt != wc || cmd !== 16'h0000 || vld !== 1'b0)
            $display("FAIL %s idle_quiet: extra_wrt=%0d cmd=%h vld=%b want 0/0000/0", nm, wrt_cnt - wc, cmd, vld);
        else n_pass++;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        n_total++;
        if (wrt !== 1'b0 || vld !== 1'b0) $display("FAIL reset_ctl: wrt=%b vld=%b want 0/0", wrt, vld);
        else n_pass++;
        n_total++;
        if (cmd !== 16'h0000) $display("FAIL reset_cmd: got %h want 0000", cmd);
        else n_pass++;
        n_total++;
        if (ptch_rt !== 16'h0000 || AZ !== 16'h0000)
            $display("FAIL reset_data: ptch_rt=%h AZ=%h want 0000/0000", ptch_rt, AZ);
        else n_pass++;
    endtask

    task automatic test_init();
        rst_n = 1'b1;
        run_init("init");
    endtask

    task automatic test_read_burst();
        INT = 1'b1;
        burst({8'hAB, 8'hCD, 8'h12, 8'h34}, 3, 1'b0, 1'b0, "read_1234");
    endtask

    task automatic test_signed_extremes();
        int wc;
        INT = 1'b1;
        burst({8'h7F, 8'hFF, 8'h80, 8'h00}, 2, 1'b0, 1'b0, "extremes");
        n_total++;
        if ($signed(ptch_rt) != -32768 || $signed(AZ) != 32767)
            $display("FAIL extremes_signed: ptch_rt=%0d AZ=%0d want -32768/32767", $signed(ptch_rt), $signed(AZ));
        else n_pass++;
        wc = wrt_cnt;
        repeat (10) @(negedge clk);
        n_total++;
        if (ptch_rt !== exp_p || AZ !== exp_a || wrt_cnt != wc)
            $display("FAIL extremes_hold: ptch_rt=%h AZ=%h want %h/%h", ptch_rt, AZ, exp_p, exp_a);
        else n_pass++;
    endtask

    task automatic test_random_bursts();
        for (int k = 0; k < 6; k++) begin
            logic [3:0][7:0] b;
            b = {$urandom_range(0, 255), $urandom_range(0, 255), $urandom_range(0, 255), $urandom_range(0, 255)};
            INT = 1'b1;
            burst(b, 4, 1'b0, 1'b0, "random");
            repeat ($urandom_range(0, 5)) @(negedge clk);
        end
    endtask

    task automatic test_back_to_back();
        int vc = vld_cnt;
        int wc = wrt_cnt;
        INT = 1'b1;
        for (int k = 0; k < 4; k++) begin
            logic [3:0][7:0] b;
            b = {$urandom_range(0, 255), $urandom_range(0, 255), $urandom_range(0, 255), $urandom_range(0, 255)};
            if (k == 3) INT = 1'b0;
            burst(b, 3, 1'b1, 1'b0, "back_to_back");
        end
        repeat (10) @(negedge clk);
        n_total++;
        if (vld_cnt != vc + 4 || wrt_cnt != wc + 16)
            $display("FAIL back_to_back_counts: vld=%0d wrt=%0d want 4/16", vld_cnt - vc, wrt_cnt - wc);
        else n_pass++;
    endtask

    task automatic test_spurious();
        int vc = vld_cnt;
        int wc = wrt_cnt;
        logic [3:0][7:0] b;
        spi_done = 1'b1;
        spi_rd_data = 8'h5A;
        @(negedge clk);
        spi_done = 1'b0;
        repeat (5) @(negedge clk);
        n_total++;
        if (wrt_cnt != wc || vld_cnt != vc || ptch_rt !== exp_p || AZ !== exp_a || cmd !== 16'h0000)
            $display("FAIL spurious_idle: wrt=%0d vld=%0d ptch_rt=%h AZ=%h want 0/0/%h/%h",
                     wrt_cnt - wc, vld_cnt - vc, ptch_rt, AZ, exp_p, exp_a);
        else n_pass++;
        b = {$urandom_range(0, 255), $urandom_range(0, 255), $urandom_range(0, 255), $urandom_range(0, 255)};
        INT = 1'b1;
        burst(b, 3, 1'b0, 1'b1, "spurious_wrt");
    endtask

    task automatic test_reset_mid();
        int n = 0;
        INT = 1'b1;
        serve(16'hA400, 8'h77, 2, 1'b0, "reset_mid");
        INT = 1'b0;
        while (wrt !== 1'b1 && n < 64) begin
            @(negedge clk);
            n++;
        end
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        spi_done = 1'b1;
        spi_rd_data = 8'hEE;
        n_total++;
        if (wrt !== 1'b0 || vld !== 1'b0 || cmd !== 16'h0000 || ptch_rt !== 16'h0000 || AZ !== 16'h0000)
            $display("FAIL reset_mid_outputs: wrt=%b vld=%b cmd=%h ptch_rt=%h AZ=%h want all 0",
                     wrt, vld, cmd, ptch_rt, AZ);
        else n_pass++;
        exp_p = 16'h0000;
        exp_a = 16'h0000;
        run_init("reinit");
        n_total++;
        if (ptch_rt !== 16'h0000 || AZ !== 16'h0000)
            $display("FAIL reinit_data: ptch_rt=%h AZ=%h want 0000/0000", ptch_rt, AZ);
        else n_pass++;
    endtask

    initial begin
        test_reset();
        test_init();
        test_read_burst();
        test_signed_extremes();
        test_random_bursts();
        test_back_to_back();
        test_spurious();
        test_reset_mid();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
